// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared FSM state type and widths for the CPU data memory
package cpu_mem_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 16;
  typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones, with synchronous clear
module sat_counter
  import cpu_mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/cpu_data_mem.sv
// cpu_data_mem: word-addressed CPU data RAM with zero-latency loads, self-clear after reset,
// sticky access-error flags and saturating access counters
module cpu_data_mem
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       MemAdr,
  input  logic [DATA_W-1:0] memWriteData,
  input  logic              MemoryRead,
  input  logic              MemoryWrite,
  output logic [DATA_W-1:0] memReadData,
  output logic              memReady,
  output logic              alignErr,
  output logic              rangeErr,
  output logic              bothErr,
  output logic [CNT_W-1:0]  rdCount,
  output logic [CNT_W-1:0]  wrCount
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  state_t state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic align_q, align_d, range_q, range_d, both_q, both_d;
  logic ready, req, mis, oor, valid, rd_ok, wr_ok, we;
  logic [AW-1:0] idx, w_idx;
  logic [DATA_W-1:0] w_data;
  always_comb begin
    ready = state_q == READY;
    req = ready && (MemoryRead || MemoryWrite);
    mis = MemAdr[1:0] != 2'b00;
    oor = MemAdr >= LIMIT;
    valid = !mis && !oor;
    idx = MemAdr[AW+1:2];
    rd_ok = ready && MemoryRead && valid;
    wr_ok = ready && MemoryWrite && valid && !rst;
    // single write port: clear engine owns it until READY, then the CPU
    we = !ready || wr_ok;
    w_idx = ready ? idx : clr_idx_q;
    w_data = ready ? memWriteData : '0;
    state_d = rst ? CLEAR : (!ready && clr_idx_q == AW'(DEPTH_WORDS - 1)) ? READY : state_q;
    clr_idx_d = rst ? '0 : ready ? clr_idx_q : clr_idx_q + 1'b1;
    align_d = !rst && (align_q || (req && mis));
    range_d = !rst && (range_q || (req && oor));
    both_d = !rst && (both_q || (ready && MemoryRead && MemoryWrite));
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    clr_idx_q <= clr_idx_d;
    align_q <= align_d;
    range_q <= range_d;
    both_q <= both_d;
  end
  always_ff @(posedge clk) if (we) mem_q[w_idx] <= w_data;
  assign memReadData = rd_ok ? mem_q[idx] : '0;
  assign memReady = ready;
  assign alignErr = align_q;
  assign rangeErr = range_q;
  assign bothErr = both_q;
  sat_counter #(.W(CNT_W)) u_rd_cnt (.clk(clk), .clr(rst), .inc(rd_ok), .cnt(rdCount));
  sat_counter #(.W(CNT_W)) u_wr_cnt (.clk(clk), .clr(rst), .inc(wr_ok), .cnt(wrCount));
endmodule

// File: tb/tb_cpu_data_mem.sv
// tb_cpu_data_mem: scoreboard bench for cpu_data_mem at DEPTH_WORDS=256
module tb_cpu_data_mem;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] MemAdr = '0, memWriteData = '0;
  logic MemoryRead = 1'b0, MemoryWrite = 1'b0;
  logic [31:0] memReadData;
  logic memReady, alignErr, rangeErr, bothErr;
  logic [15:0] rdCount, wrCount;

  cpu_data_mem #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst), .MemAdr(MemAdr), .memWriteData(memWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .memReadData(memReadData),
    .memReady(memReady), .alignErr(alignErr), .rangeErr(rangeErr), .bothErr(bothErr),
    .rdCount(rdCount), .wrCount(wrCount)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] adr; logic [31:0] val;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  logic [31:0] mdl_mem [256];
  int mdl_rd, mdl_wr;
  logic mdl_al, mdl_rg, mdl_bo;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (memReadData !== mon_e.val) begin
        errors++;
        $display("FAIL read_data adr=%h got %h expected %h", mon_e.adr, memReadData, mon_e.val);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] adr, input logic [31:0] data);
    logic valid;
    logic [31:0] e;
    @(posedge clk); #1;
    MemoryRead = rd; MemoryWrite = wr; MemAdr = adr; memWriteData = data;
    valid = adr[1:0] == 2'b00 && adr < 32'h400;
    e = (rd && valid) ? mdl_mem[adr[9:2]] : 32'h0;
    exp_q.push_back('{adr, e});
    if ((rd || wr) && adr[1:0] != 2'b00) mdl_al = 1'b1;
    if ((rd || wr) && adr >= 32'h400) mdl_rg = 1'b1;
    if (rd && wr) mdl_bo = 1'b1;
    if (rd && valid && mdl_rd < 65535) mdl_rd++;
    if (wr && valid && mdl_wr < 65535) mdl_wr++;
    if (wr && valid) mdl_mem[adr[9:2]] = data;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MemoryRead = 1'b0; MemoryWrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset(input int mid_abort);
    int n, bad;
    logic done;
    @(posedge clk); #1;
    rst = 1'b1; MemoryRead = 1'b1; MemoryWrite = 1'b1; MemAdr = 32'h10; memWriteData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    if (mid_abort > 0) begin
      repeat (mid_abort) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    mdl_rd = 0; mdl_wr = 0; mdl_al = 1'b0; mdl_rg = 1'b0; mdl_bo = 1'b0;
    n = 0; bad = 0; done = 1'b0;
    while (!done && n < 1000) begin
      @(negedge clk);
      if (memReady) done = 1'b1;
      else begin
        if (memReadData !== 32'h0 || rdCount !== 16'h0 || wrCount !== 16'h0 ||
            alignErr !== 1'b0 || rangeErr !== 1'b0 || bothErr !== 1'b0) bad++;
        n++;
        MemAdr = (n % 3 == 0) ? 32'h10 : (n % 3 == 1) ? 32'h13 : 32'h400;
      end
    end
    MemoryRead = 1'b0; MemoryWrite = 1'b0;
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL clear_cycles got %0d expected 256", n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_ignores_requests got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_reset();
    apply_reset(100);
    checks++;
    if (rdCount !== 16'h0 || wrCount !== 16'h0 || {alignErr, rangeErr, bothErr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got rd=%h wr=%h flags=%b expected 0 0 000", rdCount, wrCount, {alignErr, rangeErr, bothErr});
    end
    access(1'b1, 1'b0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 32'h3FC, 32'h0);
    idle();
  endtask

  task automatic test_store_load();
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    idle();
    checks++;
    if (wrCount !== 16'd1 || rdCount !== 16'd3) begin
      errors++;
      $display("FAIL store_load_counts got rd=%0d wr=%0d expected rd=3 wr=1", rdCount, wrCount);
    end
  endtask

  task automatic test_same_cycle();
    access(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h20, 32'h0);
    idle();
    checks++;
    if (bothErr !== 1'b1 || alignErr !== 1'b0 || rangeErr !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_flags got %b expected 100", {bothErr, alignErr, rangeErr});
    end
    checks++;
    if (rdCount !== 16'(mdl_rd) || wrCount !== 16'(mdl_wr)) begin
      errors++;
      $display("FAIL same_cycle_counts got rd=%0d wr=%0d expected rd=%0d wr=%0d", rdCount, wrCount, mdl_rd, mdl_wr);
    end
  endtask

  task automatic test_errors();
    access(1'b0, 1'b1, 32'h13, 32'hAAAA_5555);
    idle();
    checks++;
    if (alignErr !== 1'b1 || rangeErr !== 1'b0) begin
      errors++;
      $display("FAIL align_only got align=%b range=%b expected 1 0", alignErr, rangeErr);
    end
    access(1'b0, 1'b1, 32'h400, 32'h5555_AAAA);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    access(1'b1, 1'b0, 32'h12, 32'h0);
    access(1'b1, 1'b0, 32'h7FC, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    idle();
    checks++;
    if (alignErr !== 1'b1 || rangeErr !== 1'b1) begin
      errors++;
      $display("FAIL error_flags got align=%b range=%b expected 1 1", alignErr, rangeErr);
    end
    checks++;
    if (wrCount !== 16'(mdl_wr) || rdCount !== 16'(mdl_rd)) begin
      errors++;
      $display("FAIL error_counts got rd=%0d wr=%0d expected rd=%0d wr=%0d", rdCount, wrCount, mdl_rd, mdl_wr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [16];
    for (int i = 0; i < 16; i++) begin
      adrs[i] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      access(1'b0, 1'b1, adrs[i], $urandom);
      access(1'b1, 1'b0, adrs[$urandom_range(0, i)], 32'h0);
    end
    for (int i = 0; i < 16; i++) access(1'b1, (i % 4) == 3, adrs[i], $urandom);
    idle();
    checks++;
    if (wrCount !== 16'(mdl_wr) || rdCount !== 16'(mdl_rd)) begin
      errors++;
      $display("FAIL b2b_counts got rd=%0d wr=%0d expected rd=%0d wr=%0d", rdCount, wrCount, mdl_rd, mdl_wr);
    end
  endtask

  task automatic test_saturation();
    repeat (65537) access(1'b1, 1'b0, 32'h10, 32'h0);
    idle();
    checks++;
    if (rdCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL rd_saturate got %h expected ffff", rdCount);
    end
    repeat (3) access(1'b1, 1'b0, 32'h10, 32'h0);
    apply_reset(0);
    checks++;
    if (rdCount !== 16'h0 || wrCount !== 16'h0 || {alignErr, rangeErr, bothErr} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_state got rd=%h wr=%h flags=%b expected 0 0 000", rdCount, wrCount, {alignErr, rangeErr, bothErr});
    end
    access(1'b1, 1'b0, 32'h10, 32'h0);
    access(1'b1, 1'b0, 32'h20, 32'h0);
    idle();
    checks++;
    if (rdCount !== 16'd2) begin
      errors++;
      $display("FAIL post_reset_rdcount got %0d expected 2", rdCount);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_same_cycle();
    test_errors();
    test_back_to_back();
    test_saturation();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
